// File: rtl/sprite_rle_loader.sv
// Run-length-encoded sprite loader: expands 8-bit tokens (run, palette index) into
// sequential pixel writes into one of NUM_FRAMES frame banks.
module sprite_rle_loader #(
  parameter int unsigned FRAME_PIXELS = 18200,
  parameter int unsigned NUM_FRAMES   = 8,
  parameter int unsigned ADDR_W       = 19
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          start,
  input  logic [$clog2(NUM_FRAMES)-1:0] frame_sel,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          wr_en,
  output logic [NUM_FRAMES-1:0]         wr_bank,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [3:0]                    wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int unsigned BankW = $clog2(NUM_FRAMES);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {StIdle, StAccept, StExpand, StDone} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         remaining_q, remaining_d;
  logic [3:0]         color_q, color_d;
  logic [BankW-1:0]   bank_q, bank_d;
  logic               overrun_q, overrun_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      color_q     <= '0;
      bank_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      color_q     <= color_d;
      bank_q      <= bank_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    color_d     = color_q;
    bank_d      = bank_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bank_d    = frame_sel;
          addr_d    = '0;
          overrun_d = 1'b0;
          state_d   = StAccept;
        end
      end
      StAccept: begin
        if (in_valid) begin
          color_d     = in_data[3:0];
          remaining_d = in_data[7:4];
          state_d     = StExpand;
        end
      end
      StExpand: begin
        // The last pixel ends the frame; any leftover run is dropped and flagged.
        if (addr_q == LastAddr) begin
          if (remaining_q != 4'd0) begin
            overrun_d = 1'b1;
          end
          state_d = StDone;
        end else if (remaining_q == 4'd0) begin
          addr_d  = addr_q + 1'b1;
          state_d = StAccept;
        end else begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All outputs are decoded purely from registered state.
  always_comb begin
    in_ready = (state_q == StAccept);
    wr_en    = (state_q == StExpand);
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    overrun  = overrun_q;
    wr_addr  = '0;
    wr_data  = '0;
    wr_bank  = '0;
    if (state_q == StExpand) begin
      wr_addr = addr_q;
      wr_data = color_q;
      wr_bank = NUM_FRAMES'(1) << bank_q;
    end
  end

endmodule

// File: tb/tb_sprite_rle_loader.sv
// Directed bench for sprite_rle_loader: full frames, latency, overrun, bubbles,
// ignored starts and mid-run reset, with a negedge write monitor.
module tb_sprite_rle_loader;

  localparam int unsigned FramePixels = 18200;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [2:0]  frame_sel;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_bank;
  logic [18:0] wr_addr;
  logic [3:0]  wr_data;
  logic        busy;
  logic        done;
  logic        overrun;

  sprite_rle_loader #(
    .FRAME_PIXELS(FramePixels),
    .NUM_FRAMES  (8),
    .ADDR_W      (19)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .frame_sel(frame_sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: expects contiguous addresses from 0 with the current token colour/bank.
  logic        mon_clr;
  logic [3:0]  exp_color;
  logic [7:0]  exp_bank;
  logic [18:0] mon_addr;
  int          mon_cnt;
  int          mon_err;
  int          mon_done;

  always @(negedge Clk) begin
    if (mon_clr) begin
      mon_addr <= '0;
      mon_cnt  <= 0;
      mon_err  <= 0;
      mon_done <= 0;
    end else begin
      if (wr_en) begin
        mon_cnt  <= mon_cnt + 1;
        mon_addr <= mon_addr + 19'd1;
        if (wr_addr !== mon_addr || wr_data !== exp_color || wr_bank !== exp_bank)
          mon_err <= mon_err + 1;
      end
      if (done) mon_done <= mon_done + 1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic hard_reset();
    in_valid = 1'b0;
    start    = 1'b0;
    Reset    = 1'b1;
    tick();
    Reset    = 1'b0;
  endtask

  task automatic start_frame(input logic [2:0] sel);
    frame_sel = sel;
    start     = 1'b1;
    mon_clr   = 1'b1;
    exp_bank  = 8'd1 << sel;
    tick();
    start     = 1'b0;
    mon_clr   = 1'b0;
  endtask

  // Returns one cycle after acceptance (first write cycle of the token).
  task automatic send(input logic [7:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 64) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    in_valid  = 1'b0;
    exp_color = d[3:0];
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] toks [5];
    int         idx;
    logic       v;
    logic       acc;
    int         n;

    Reset = 1'b1; start = 1'b0; frame_sel = '0; in_valid = 1'b0; in_data = '0;
    mon_clr = 1'b1; exp_color = '0; exp_bank = '0;
    tick();
    tick();
    check_eq("rst_ctl", {27'd0, in_ready, wr_en, busy, done, overrun}, 32'd0);
    check_eq("rst_bus", {1'b0, wr_bank, wr_addr, wr_data}, 32'd0);
    Reset = 1'b0;
    tick();
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Latency of a single 3-pixel token with valid held.
    start_frame(3'd0);
    check_eq("acc_ready", {31'd0, in_ready}, 32'd1);
    check_eq("acc_busy", {31'd0, busy}, 32'd1);
    send(8'h2A);
    in_valid = 1'b1;
    check_eq("lat_w0", {12'd0, wr_en, wr_addr}, {12'd0, 1'b1, 19'd0});
    check_eq("lat_d0", {28'd0, wr_data}, 32'hA);
    check_eq("lat_rdy0", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("lat_w1", {12'd0, wr_en, wr_addr}, {12'd0, 1'b1, 19'd1});
    tick();
    check_eq("lat_w2", {12'd0, wr_en, wr_addr}, {12'd0, 1'b1, 19'd2});
    check_eq("lat_rdy2", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("lat_rdy3", {30'd0, in_ready, wr_en}, 32'b10);
    check_eq("lat_cnt", mon_cnt, 32'd3);
    hard_reset();

    // Bubble handshake: valid toggles every cycle.
    toks = '{8'h13, 8'h04, 8'h2B, 8'h00, 8'h1E};
    start_frame(3'd5);
    idx = 0;
    v   = 1'b0;
    for (int c = 0; c < 300 && idx < 5; c++) begin
      v        = ~v;
      in_valid = v;
      in_data  = toks[idx];
      acc      = v && in_ready;
      tick();
      if (acc) begin
        exp_color = toks[idx][3:0];
        idx++;
      end
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check_eq("bub_tokens", idx, 32'd5);
    check_eq("bub_cnt", mon_cnt, 32'd9);
    check_eq("bub_err", mon_err, 32'd0);
    check_eq("bub_wait", {30'd0, in_ready, busy}, 32'b11);
    hard_reset();

    // Reset while expanding at address 500, then restart from 0.
    start_frame(3'd4);
    repeat (31) send(8'hF1);
    send(8'h91);
    n = 0;
    while (wr_addr != 19'd500 && n < 40) begin
      tick();
      n++;
    end
    check_eq("mid_at500", {12'd0, wr_en, wr_addr}, {12'd0, 1'b1, 19'd500});
    Reset = 1'b1;
    tick();
    check_eq("mid_rst_ctl", {27'd0, in_ready, wr_en, busy, done, overrun}, 32'd0);
    check_eq("mid_rst_bus", {1'b0, wr_bank, wr_addr, wr_data}, 32'd0);
    Reset = 1'b0;
    start_frame(3'd1);
    send(8'h03);
    check_eq("mid_restart", {wr_en, wr_bank, wr_addr, wr_data}, {1'b1, 8'h02, 19'd0, 4'h3});
    hard_reset();

    // Full frame into bank 3.
    start_frame(3'd3);
    repeat (1137) send(8'hF5);
    send(8'h75);
    repeat (8) tick();
    check_eq("f1_done", {29'd0, done, busy, wr_en}, 32'b110);
    check_eq("f1_ovr", {31'd0, overrun}, 32'd0);
    tick();
    check_eq("f1_after", {30'd0, done, busy}, 32'd0);
    check_eq("f1_cnt", mon_cnt, FramePixels);
    check_eq("f1_err", mon_err, 32'd0);
    check_eq("f1_ndone", mon_done, 32'd1);
    check_eq("f1_lastaddr", {13'd0, mon_addr}, FramePixels);

    // Starts while busy (EXPAND, ACCEPT, DONE) are ignored.
    start_frame(3'd2);
    for (int i = 0; i < 1138; i++) begin
      send(i == 1137 ? 8'h75 : 8'hF5);
      if (i == 100) begin
        frame_sel = 3'd6;
        start     = 1'b1;
        tick();
        start     = 1'b0;
      end
      if (i == 200) begin
        repeat (16) tick();
        check_eq("f5_in_accept", {31'd0, in_ready}, 32'd1);
        frame_sel = 3'd6;
        start     = 1'b1;
        tick();
        start     = 1'b0;
      end
    end
    repeat (8) tick();
    check_eq("f5_done", {31'd0, done}, 32'd1);
    frame_sel = 3'd6;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check_eq("f5_idle", {30'd0, busy, in_ready}, 32'd0);
    tick();
    check_eq("f5_stay_idle", {30'd0, busy, in_ready}, 32'd0);
    check_eq("f5_cnt", mon_cnt, FramePixels);
    check_eq("f5_err", mon_err, 32'd0);
    check_eq("f5_ndone", mon_done, 32'd1);

    // Overrun on the last token, then cleared by a new start.
    start_frame(3'd0);
    repeat (FramePixels - 2) send(8'h0C);
    send(8'h47);
    check_eq("ov_w0", {13'd0, wr_addr}, FramePixels - 2);
    tick();
    check_eq("ov_w1", {13'd0, wr_addr}, FramePixels - 1);
    tick();
    check_eq("ov_done", {29'd0, done, overrun, wr_en}, 32'b110);
    tick();
    check_eq("ov_sticky", {30'd0, overrun, busy}, 32'b10);
    check_eq("ov_cnt", mon_cnt, FramePixels);
    check_eq("ov_err", mon_err, 32'd0);
    check_eq("ov_ndone", mon_done, 32'd1);
    start_frame(3'd4);
    check_eq("ov_cleared", {31'd0, overrun}, 32'd0);
    hard_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_rle_loader.md
Name: sprite_rle_loader

Overview:
Writer side of the 4-bit palette-indexed sprite frame memories. The game-side animation readers fetch one nibble per pixel from these memories.
The block accepts a run-length-encoded byte stream (from the NIOS/SRAM path) over a valid/ready handshake. It expands each token into consecutive pixel writes and targets one of NUM_FRAMES frame banks, each 200x91 = 18200 entries.
It sits between the loader bus and the write ports of the frame RAMs, one bank-enable per frame.

Parameters:
FRAME_PIXELS, 18200, number of entries per frame bank (200 wide x 91 high)
NUM_FRAMES, 8, number of frame banks (animation states 0..7)
ADDR_W, 19, width of the write address bus into a frame bank

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to load one frame; ignored unless idle
frame_sel  input  3  target bank, sampled only on an accepted start
in_valid  input  1  token present on in_data
in_data  input  8  token: [7:4] run field r (run length r+1, 1..16), [3:0] palette index
in_ready  output  1  block will consume in_data this cycle if in_valid
wr_en  output  1  write strobe to frame RAM
wr_bank  output  8  one-hot bank enable; equals 1<<frame_sel_latched when wr_en, else 0
wr_addr  output  ADDR_W  pixel address: row*200 + col, row-major
wr_data  output  4  palette index to write
busy  output  1  high from accepted start until the cycle after done
done  output  1  one-cycle pulse when a frame is complete
overrun  output  1  sticky: a token extended past the last pixel; cleared by the next accepted start or by Reset

Behaviour:
- Clock and reset: single clock Clk. Reset is synchronous and active-high. When Reset is sampled high, the FSM goes to IDLE and every output is 0 in the following cycle: in_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done, overrun. Internal address and run counters are also cleared.
- Reset mid-operation: no further writes are issued. Any partially loaded frame is left as is; no done pulse is generated.
- State registers: state, addr (ADDR_W), remaining (4), color (4), bank (3).
- Outputs are decoded only from these registers, never from inputs in the same cycle.
- IDLE: in_ready=0, busy=0.
  - On start=1: latch bank<=frame_sel, addr<=0, overrun<=0, then go to ACCEPT.
- ACCEPT: in_ready=1, busy=1, wr_en=0.
  - If in_valid: color<=in_data[3:0], remaining<=in_data[7:4], then go to EXPAND.
  - If not in_valid: stay in ACCEPT. There is no timeout.
- EXPAND: in_ready=0, wr_en=1, wr_addr=addr, wr_data=color, wr_bank=1<<bank. Exactly one pixel is written per cycle.
  - If addr==FRAME_PIXELS-1: if remaining!=0, set overrun<=1 and discard the rest of the run. Go to DONE.
  - Else if remaining==0: addr<=addr+1, go to ACCEPT.
  - Else: addr<=addr+1, remaining<=remaining-1, stay in EXPAND.
- DONE: done=1 for exactly this cycle, busy=1, then go to IDLE. A start arriving in DONE is ignored.
- Latency: a token accepted at cycle t produces writes at cycles t+1 .. t+r+1. in_ready is high again at cycle t+r+2. Throughput is r+1 pixels per r+2 cycles.
- start asserted while busy has no effect: frame_sel is not re-latched and progress is unaffected.
- Arithmetic: addr is unsigned and compared against FRAME_PIXELS-1, with no modulo wrap. Bit widths are zero-extended.
- in_data is ignored whenever in_ready=0. The upstream source must hold the token until in_valid and in_ready are both high.
- Total writes per completed frame are exactly FRAME_PIXELS, with addresses 0..FRAME_PIXELS-1 each written once, in order.

Test Plan:
1. Reset, start with frame_sel=3, then 1137 tokens of 0xF5 (16 px each) plus a final token 0x75 (8 px) -> 18200 writes, addr 0..18199, wr_data=5, wr_bank=8'h08. done pulses once, the cycle after the write to 18199. overrun=0, busy falls next cycle.
2. Single token 0x2A with in_valid held: accepted at t -> wr_en at t+1..t+3 with addr 0,1,2 and data A. in_ready=0 during t+1..t+3 and =1 at t+4.
3. Overrun: frame_sel=0. Load 18198 pixels using run-1 tokens (0x0C), then token 0x47 -> writes at 18198 and 18199 only. The 3 excess pixels are dropped, overrun=1, done=1. A new start clears overrun to 0.
4. Bubble handshake: toggle in_valid 1/0 every cycle during ACCEPT -> no token is lost or duplicated, and the address sequence is contiguous.
5. start pulse with frame_sel=6 mid-load of frame 2 -> ignored; wr_bank stays 8'h04 to completion.
6. Reset asserted while in EXPAND at addr=500 -> the next cycle has wr_en=0 and all outputs 0. Start with frame_sel=1 then resumes from addr 0.
